// File: rtl/fare_collector_if.sv
// fare_collector_if
//   Groups the passenger-side and dispense-unit-side signals of the fare
//   collector into one bundle.
//   slave  : view used by fare_collector (coin/cancel/completion in,
//            dispense start, credit and status out).
//   master : view used by whatever drives the collector (testbench, panel).
//   Signals:
//     coin_in     coin-present strobe, one cycle per coin
//     coin_val    denomination with coin_in: 00=1, 01=2, 10=5, 11=10
//     cancel      passenger cancel request
//     state_cmp9  ticket-complete pulse from the dispense unit
//     out_RDY9    one-cycle start pulse to the dispense unit
//     credit      current credit, or change/refund units still owed
//     change_out  one pulse per change unit returned
//     refund_out  one pulse per refunded unit
//     coin_reject high for one cycle after a coin arrives outside COLLECT
//     busy        high whenever the controller is not in COLLECT
//     fault       dispense-timeout fault, cleared only by reset
interface fare_collector_if;
    logic       coin_in;
    logic [1:0] coin_val;
    logic       cancel;
    logic       state_cmp9;
    logic       out_RDY9;
    logic [4:0] credit;
    logic       change_out;
    logic       refund_out;
    logic       coin_reject;
    logic       busy;
    logic       fault;

    modport slave (
        input  coin_in, coin_val, cancel, state_cmp9,
        output out_RDY9, credit, change_out, refund_out, coin_reject, busy, fault
    );

    modport master (
        output coin_in, coin_val, cancel, state_cmp9,
        input  out_RDY9, credit, change_out, refund_out, coin_reject, busy, fault
    );
endinterface

// File: rtl/fare_collector.sv
// fare_collector
//   Payment-side controller of the ticket vending machine. Accumulates coin
//   credit against FARE, pulses out_RDY9 to start the dispense unit, waits
//   for state_cmp9, then pays back overpayment one unit per cycle. Also
//   handles passenger cancel, inactivity refund and a dispense-timeout fault.
//   Parameters:
//     FARE          ticket price in credit units (1..15)
//     CMP_TIMEOUT   cycles allowed in WAIT_CMP before FAULT
//     INACT_TIMEOUT coin-free cycles (credit > 0) before automatic refund
//   Ports:
//     clk  rising-edge system clock
//     rst  asynchronous active-low reset
//     bus  fare_collector_if.slave (see interface file for signal list)
module fare_collector #(
    parameter int unsigned FARE          = 9,
    parameter int unsigned CMP_TIMEOUT   = 64,
    parameter int unsigned INACT_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    fare_collector_if.slave  bus
);

    localparam int unsigned CMP_W   = $clog2(CMP_TIMEOUT + 1);
    localparam int unsigned INACT_W = $clog2(INACT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_ISSUE,
        S_WAIT_CMP,
        S_CHANGE,
        S_REFUND,
        S_FAULT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_credit;
    logic [4:0]           w_credit_nxt;
    logic [CMP_W-1:0]     r_cmp_cnt;
    logic [CMP_W-1:0]     w_cmp_cnt_nxt;
    logic [CMP_W-1:0]     w_cmp_inc;
    logic [INACT_W-1:0]   r_inact_cnt;
    logic [INACT_W-1:0]   w_inact_cnt_nxt;
    logic [INACT_W-1:0]   w_inact_inc;
    logic                 r_coin_reject;
    logic                 w_coin_reject_nxt;
    logic [4:0]           w_coin_amt;
    logic [4:0]           w_sum;
    logic [4:0]           w_after_fare;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_COLLECT;
            r_credit      <= '0;
            r_cmp_cnt     <= '0;
            r_inact_cnt   <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_cmp_cnt     <= w_cmp_cnt_nxt;
            r_inact_cnt   <= w_inact_cnt_nxt;
            r_coin_reject <= w_coin_reject_nxt;
        end
    end

    always_comb begin
        w_coin_amt = 5'd1;
        unique case (bus.coin_val)
            2'b00: w_coin_amt = 5'd1;
            2'b01: w_coin_amt = 5'd2;
            2'b10: w_coin_amt = 5'd5;
            2'b11: w_coin_amt = 5'd10;
            default: w_coin_amt = 5'd1;
        endcase
    end

    // Credit never exceeds FARE-1+10 <= 24 in COLLECT, so 5 bits cannot wrap
    assign w_sum        = r_credit + (bus.coin_in ? w_coin_amt : 5'd0);
    assign w_after_fare = r_credit - 5'(FARE);
    assign w_cmp_inc    = r_cmp_cnt + CMP_W'(1);
    assign w_inact_inc  = r_inact_cnt + INACT_W'(1);

    // Next-state and datapath logic
    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_cmp_cnt_nxt     = '0;
        w_inact_cnt_nxt   = '0;
        w_coin_reject_nxt = bus.coin_in && (r_state != S_COLLECT);

        unique case (r_state)
            S_COLLECT: begin
                w_credit_nxt = w_sum;
                // Idle timer runs only while some credit is held and no coin arrives
                if (!bus.coin_in && (r_credit != '0)) begin
                    w_inact_cnt_nxt = w_inact_inc;
                end
                // Cancel has priority over reaching the fare
                if (bus.cancel && (w_sum != '0)) begin
                    w_state_nxt     = S_REFUND;
                    w_inact_cnt_nxt = '0;
                end else if (bus.coin_in && (w_sum >= 5'(FARE))) begin
                    w_state_nxt     = S_ISSUE;
                    w_inact_cnt_nxt = '0;
                end else if (!bus.coin_in && (r_credit != '0) &&
                             (w_inact_inc == INACT_W'(INACT_TIMEOUT))) begin
                    w_state_nxt     = S_REFUND;
                    w_inact_cnt_nxt = '0;
                end
            end

            S_ISSUE: begin
                w_state_nxt = S_WAIT_CMP;
            end

            S_WAIT_CMP: begin
                // Completion on the timeout edge still counts as completion
                if (bus.state_cmp9) begin
                    w_credit_nxt = w_after_fare;
                    w_state_nxt  = (w_after_fare != '0) ? S_CHANGE : S_COLLECT;
                end else begin
                    w_cmp_cnt_nxt = w_cmp_inc;
                    if (w_cmp_inc == CMP_W'(CMP_TIMEOUT)) begin
                        w_state_nxt   = S_FAULT;
                        w_cmp_cnt_nxt = '0;
                    end
                end
            end

            S_CHANGE, S_REFUND: begin
                if (r_credit <= 5'd1) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = S_COLLECT;
                end else begin
                    w_credit_nxt = r_credit - 5'd1;
                end
            end

            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end

            default: begin
                w_state_nxt  = S_COLLECT;
                w_credit_nxt = '0;
            end
        endcase
    end

    // Moore outputs decoded from registered state only
    assign bus.out_RDY9    = (r_state == S_ISSUE);
    assign bus.credit      = r_credit;
    assign bus.change_out  = (r_state == S_CHANGE);
    assign bus.refund_out  = (r_state == S_REFUND);
    assign bus.coin_reject = r_coin_reject;
    assign bus.busy        = (r_state != S_COLLECT);
    assign bus.fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_fare_collector.sv
// tb_fare_collector
//   Directed self-checking bench for fare_collector with FARE=9,
//   CMP_TIMEOUT=64, INACT_TIMEOUT=200. Inputs change 1 ns after a rising
//   edge; outputs are checked 1 ns after the edge that should update them.
module tb_fare_collector;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fare_collector_if bus();

    fare_collector #(
        .FARE          (9),
        .CMP_TIMEOUT   (64),
        .INACT_TIMEOUT (200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [1:0] v, input logic with_cancel);
        bus.coin_in  = 1'b1;
        bus.coin_val = v;
        bus.cancel   = with_cancel;
        tick();
        bus.coin_in  = 1'b0;
        bus.cancel   = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst            = 1'b0;
        bus.coin_in    = 1'b0;
        bus.coin_val   = 2'b00;
        bus.cancel     = 1'b0;
        bus.state_cmp9 = 1'b0;

        // Reset state
        #2;
        chk("rst_credit", 32'(bus.credit), 32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_rdy",    32'(bus.out_RDY9), 32'd0);
        chk("rst_fault",  32'(bus.fault),  32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Cancel with no credit is ignored
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel0_busy",   32'(bus.busy),       32'd0);
        chk("cancel0_refund", 32'(bus.refund_out), 32'd0);

        // Exact fare: 5,2,2 back to back
        coin(2'b10, 1'b0);
        chk("t1_credit5", 32'(bus.credit), 32'd5);
        coin(2'b01, 1'b0);
        chk("t1_credit7", 32'(bus.credit), 32'd7);
        chk("t1_rdy_early", 32'(bus.out_RDY9), 32'd0);
        coin(2'b01, 1'b0);
        chk("t1_credit9", 32'(bus.credit), 32'd9);
        chk("t1_rdy_hi",  32'(bus.out_RDY9), 32'd1);
        chk("t1_busy",    32'(bus.busy), 32'd1);
        tick();
        chk("t1_rdy_lo",  32'(bus.out_RDY9), 32'd0);
        chk("t1_wait_busy", 32'(bus.busy), 32'd1);
        bus.state_cmp9 = 1'b1;
        tick();
        bus.state_cmp9 = 1'b0;
        chk("t1_done_credit", 32'(bus.credit), 32'd0);
        chk("t1_done_busy",   32'(bus.busy), 32'd0);
        chk("t1_no_change",   32'(bus.change_out), 32'd0);

        // Overpay with a single 10: one change unit
        coin(2'b11, 1'b0);
        chk("t2_credit10", 32'(bus.credit), 32'd10);
        chk("t2_rdy",      32'(bus.out_RDY9), 32'd1);
        tick();
        bus.state_cmp9 = 1'b1;
        tick();
        bus.state_cmp9 = 1'b0;
        chk("t2_change_hi", 32'(bus.change_out), 32'd1);
        chk("t2_credit1",   32'(bus.credit), 32'd1);
        tick();
        chk("t2_change_lo", 32'(bus.change_out), 32'd0);
        chk("t2_credit0",   32'(bus.credit), 32'd0);
        chk("t2_busy_lo",   32'(bus.busy), 32'd0);

        // Coins 2,1 then cancel: three refund pulses
        coin(2'b01, 1'b0);
        coin(2'b00, 1'b0);
        chk("t3_credit3", 32'(bus.credit), 32'd3);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("t3_ref_a", 32'(bus.refund_out), 32'd1);
        chk("t3_cr_a",  32'(bus.credit), 32'd3);
        chk("t3_rdy",   32'(bus.out_RDY9), 32'd0);
        tick();
        chk("t3_ref_b", 32'(bus.refund_out), 32'd1);
        chk("t3_cr_b",  32'(bus.credit), 32'd2);
        tick();
        chk("t3_ref_c", 32'(bus.refund_out), 32'd1);
        chk("t3_cr_c",  32'(bus.credit), 32'd1);
        tick();
        chk("t3_ref_d", 32'(bus.refund_out), 32'd0);
        chk("t3_cr_d",  32'(bus.credit), 32'd0);
        chk("t3_busy",  32'(bus.busy), 32'd0);

        // Coin together with cancel: coin is included in the refund
        coin(2'b00, 1'b1);
        chk("t3b_ref",    32'(bus.refund_out), 32'd1);
        chk("t3b_credit", 32'(bus.credit), 32'd1);
        tick();
        chk("t3b_done", 32'(bus.refund_out), 32'd0);

        // Coin reject and ignored cancel in WAIT_CMP, then timeout fault
        coin(2'b11, 1'b0);
        tick();                          // enters WAIT_CMP
        coin(2'b10, 1'b0);               // WAIT_CMP edge 1
        chk("t4_reject_hi", 32'(bus.coin_reject), 32'd1);
        chk("t4_credit",    32'(bus.credit), 32'd10);
        tick();                          // edge 2
        chk("t4_reject_lo", 32'(bus.coin_reject), 32'd0);
        bus.cancel = 1'b1;
        tick();                          // edge 3
        bus.cancel = 1'b0;
        chk("t4_cancel_busy",   32'(bus.busy), 32'd1);
        chk("t4_cancel_refund", 32'(bus.refund_out), 32'd0);
        chk("t4_cancel_credit", 32'(bus.credit), 32'd10);
        repeat (60) tick();              // edge 63
        chk("t4_fault_early", 32'(bus.fault), 32'd0);
        tick();                          // edge 64
        chk("t4_fault", 32'(bus.fault), 32'd1);
        chk("t4_fault_busy", 32'(bus.busy), 32'd1);
        bus.state_cmp9 = 1'b1;
        tick();
        bus.state_cmp9 = 1'b0;
        repeat (99) tick();
        chk("t4_fault_held",  32'(bus.fault), 32'd1);
        chk("t4_fault_cred",  32'(bus.credit), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        chk("t4_rst_fault",  32'(bus.fault), 32'd0);
        chk("t4_rst_busy",   32'(bus.busy), 32'd0);
        chk("t4_rst_credit", 32'(bus.credit), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Inactivity refund, then reset in the middle of refunding
        coin(2'b01, 1'b0);
        chk("t5_credit2", 32'(bus.credit), 32'd2);
        repeat (199) tick();
        chk("t5_not_yet", 32'(bus.refund_out), 32'd0);
        chk("t5_idle_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("t5_ref_hi",  32'(bus.refund_out), 32'd1);
        chk("t5_ref_cr",  32'(bus.credit), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_ref", 32'(bus.refund_out), 32'd0);
        chk("t5_rst_cr",  32'(bus.credit), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_after_ref", 32'(bus.refund_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fare_collector.md
# fare_collector

Payment-side controller for the ticket vending machine. It accumulates coin credit against a fixed fare and raises `out_RDY9` for one cycle to start the ticket dispense unit. It then waits for that unit's `state_cmp9` completion pulse and pays back any overpayment as change pulses. It also handles cancel/refund, inactivity refund, and a dispense-timeout fault.

## Interface
- `FARE`, default 9: ticket price in credit units, legal range 1..15.
- `CMP_TIMEOUT`, default 64: cycles allowed in WAIT_CMP before a fault is raised.
- `INACT_TIMEOUT`, default 200: coin-free cycles in COLLECT, with credit > 0, before an automatic refund.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `coin_in`  in  1  coin-present strobe; one cycle per coin.
- `coin_val`  in  2  coin denomination, valid with `coin_in`: 00=1, 01=2, 10=5, 11=10.
- `cancel`  in  1  passenger cancel request.
- `state_cmp9`  in  1  ticket-complete pulse from the dispense unit.
- `out_RDY9`  out  1  one-cycle start pulse to the dispense unit.
- `credit`  out  5  current credit or remaining change/refund units.
- `change_out`  out  1  one pulse per change unit returned.
- `refund_out`  out  1  one pulse per refunded unit.
- `coin_reject`  out  1  rejected-coin indicator.
- `busy`  out  1  high whenever the state is not COLLECT.
- `fault`  out  1  dispense-timeout fault.

## Operation
- States: COLLECT (the idle state), ISSUE, WAIT_CMP, CHANGE, REFUND, FAULT.
- `rst` low forces, immediately and asynchronously:
  - state COLLECT;
  - `credit` 0 and both timeout counters 0;
  - all outputs 0.
- COLLECT:
  - An accepted coin adds its value to `credit`. The sum is always at most FARE-1+10 = 24, so 5 bits suffice.
  - If the new sum is >= FARE, go to ISSUE.
  - `cancel` with (credit + coin) > 0 goes to REFUND.
  - `cancel` with zero credit and no coin is ignored.
  - Simultaneous coin and `cancel`: the coin is added and included in the refund. Cancel wins over ISSUE.
  - The inactivity counter clears on each accepted coin. It counts only while credit > 0. Reaching INACT_TIMEOUT goes to REFUND.
- ISSUE: `out_RDY9` = 1. Unconditionally go to WAIT_CMP on the next edge.
- WAIT_CMP:
  - On `state_cmp9` = 1, set `credit` <= credit - FARE. Go to CHANGE if that result is > 0, else go to COLLECT with credit 0.
  - The timeout counter increments every WAIT_CMP cycle. If it reaches CMP_TIMEOUT without `state_cmp9`, go to FAULT.
  - `cancel` is ignored.
- CHANGE:
  - `change_out` = 1.
  - `credit` decrements on each edge. On the edge where credit == 1, credit becomes 0 and the state returns to COLLECT.
- REFUND: same mechanism as CHANGE, using `refund_out`.
- FAULT:
  - `fault` = 1 and `credit` holds its value.
  - All inputs are ignored; the only exit is `rst`.
- Coins outside COLLECT are not added to credit and assert `coin_reject`.
- `state_cmp9` outside WAIT_CMP is ignored.

## Timing
- Inputs are sampled on the rising edge of `clk`.
- All outputs are registered Moore outputs of the state and `credit`.
- A coin sampled at edge N appears in `credit` after edge N.
- If edge N reaches the fare, ISSUE holds for the cycle after N, so `out_RDY9` is high exactly one cycle. Edge N+1 enters WAIT_CMP.
- `state_cmp9` sampled at edge M:
  - change/refund pulses begin in the cycle after M;
  - k units produce exactly k consecutive high cycles;
  - `busy` drops in the cycle after the final pulse.
- `coin_reject` is high for exactly the one cycle following the edge that sampled the rejected coin.
- Back-to-back coins on consecutive cycles are each accepted.
- WAIT_CMP timeout: FAULT is entered on the CMP_TIMEOUT-th edge spent in WAIT_CMP.
- `rst` asserted mid-CHANGE/REFUND abandons the remaining pulses with no further output.

## Test plan
- Reset, then coins 5,2,2 on consecutive cycles → `credit` 5,7,9; `out_RDY9` high exactly 1 cycle. Then `state_cmp9` pulse → COLLECT, `credit` 0, no `change_out`.
- Coins 10 then... (single coin 10, FARE 9) → ISSUE; after `state_cmp9`, exactly 1 `change_out` cycle, `credit` 1→0.
- Coins 2,1 then `cancel` → 3 consecutive `refund_out` cycles, `credit` 3,2,1→0, no `out_RDY9`.
- Coin 5 while in WAIT_CMP → `coin_reject` for 1 cycle, `credit` unchanged at 9+. `cancel` in WAIT_CMP has no effect.
- No `state_cmp9` for 64 cycles → `fault`=1 and `busy`=1, held for 100 further cycles. `rst` low → all outputs 0 immediately.
- Coin 2 then 200 idle cycles → 2 `refund_out` pulses. `rst` asserted after the first pulse → `refund_out` 0 at once and `credit` 0.
